// File: rtl/video_pkg.sv
// Shared types and constants for the text-screen VRAM blit engine.
package video_pkg;

  localparam int COLS_DEF = 64;
  localparam int ROWS_DEF = 30;
  localparam int N_DEF    = COLS_DEF * ROWS_DEF;
  localparam int AW       = 11;
  localparam int DW       = 8;

  // Engine sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COPY_RD,
    ST_COPY_WR,
    ST_CLR_ROW
  } state_t;

  // Which requester currently drives the VRAM port.
  typedef enum logic {
    OWN_CPU,
    OWN_ENG
  } owner_t;

  // CMD register bit positions.
  localparam int CMD_FILL   = 0;
  localparam int CMD_SCROLL = 1;

  // Register addresses.
  localparam logic REG_CMD  = 1'b0;
  localparam logic REG_FILL = 1'b1;

  localparam logic [DW-1:0] FILL_CHAR_RST = 8'h20;

  // One VRAM-port request as seen by the arbiter.
  typedef struct packed {
    logic          cs;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] din;
  } vram_req_t;

endpackage

// File: rtl/vram_arbiter.sv
// Per-transaction arbiter between CPU and blit engine for the VRAM port.
// The CPU has fixed priority; a stalled transaction keeps the port until it
// completes so it is never pre-empted.
module vram_arbiter
  import video_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  vram_req_t cpu_req,
  input  vram_req_t eng_req,
  input  logic      vram_wait,
  output vram_req_t vram_req,
  output logic      cpu_wait,
  output logic      eng_go
);

  owner_t owner;
  owner_t lock_own_q;
  logic   lock_q;

  // Owner selection: locked owner wins, otherwise CPU first.
  always_comb begin
    if (lock_q)           owner = lock_own_q;
    else if (cpu_req.cs)  owner = OWN_CPU;
    else                  owner = OWN_ENG;
  end

  assign vram_req = (owner == OWN_CPU) ? cpu_req : eng_req;
  assign cpu_wait = cpu_req.cs & ((owner != OWN_CPU) | vram_wait);
  assign eng_go   = (owner == OWN_ENG) & eng_req.cs & ~vram_wait;

  // Lock register: remembers who owns a transaction stalled by VRAM_WAIT.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      lock_q     <= 1'b0;
      lock_own_q <= OWN_CPU;
    end else begin
      lock_q     <= vram_req.cs & vram_wait;
      lock_own_q <= owner;
    end
  end

endmodule

// File: rtl/vram_blit_controller.sv
// Text-screen bulk-operation engine (clear-screen fill, scroll-up-one-row)
// plus CPU pass-through to the CPU-side VRAM port.
module vram_blit_controller
  import video_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reg_cs,
  input  logic          reg_wr,
  input  logic          reg_a,
  input  logic [DW-1:0] reg_din,
  output logic [DW-1:0] reg_dout,
  input  logic          cpu_cs,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_wait,
  output logic          vram_cs,
  output logic          vram_wr,
  output logic [AW-1:0] vram_a,
  output logic [DW-1:0] vram_din,
  input  logic [DW-1:0] vram_dout,
  input  logic          vram_wait,
  output logic          busy,
  output logic          done
);

  localparam int            N         = COLS * ROWS;
  localparam logic [AW-1:0] LAST      = AW'(N - 1);
  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] CLR_START = AW'(N - COLS);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] fill_char_q;
  logic          done_q, done_d;
  logic          eng_go;
  logic          cmd_wr;
  vram_req_t     cpu_req, eng_req, vram_req;

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign cmd_wr   = reg_cs & reg_wr & (reg_a == REG_CMD) & ~busy;
  assign reg_dout = (reg_a == REG_FILL) ? fill_char_q : {7'b0, busy};
  assign cpu_dout = vram_dout;

  assign cpu_req = '{cs: cpu_cs, wr: cpu_wr, a: cpu_a, din: cpu_din};

  // Engine request: reads only in COPY_RD, copy writes go one row up.
  always_comb begin
    eng_req.cs  = busy;
    eng_req.wr  = (state_q != ST_COPY_RD);
    eng_req.a   = (state_q == ST_COPY_WR) ? ptr_q - COLS_A : ptr_q;
    eng_req.din = (state_q == ST_COPY_WR) ? data_q : fill_char_q;
  end

  vram_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .eng_req  (eng_req),
    .vram_wait(vram_wait),
    .vram_req (vram_req),
    .cpu_wait (cpu_wait),
    .eng_go   (eng_go)
  );

  assign vram_cs  = vram_req.cs;
  assign vram_wr  = vram_req.wr;
  assign vram_a   = vram_req.a;
  assign vram_din = vram_req.din;

  // Next-state logic: the engine only moves on cycles it completes an access.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_wr && reg_din[CMD_FILL]) begin
          state_d = ST_FILL;
          ptr_d   = '0;
        end else if (cmd_wr && reg_din[CMD_SCROLL]) begin
          state_d = ST_COPY_RD;
          ptr_d   = COLS_A;
        end
      end
      ST_FILL, ST_CLR_ROW: begin
        if (eng_go) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_COPY_RD: begin
        if (eng_go) begin
          data_d  = vram_dout;
          state_d = ST_COPY_WR;
        end
      end
      ST_COPY_WR: begin
        if (eng_go) begin
          if (ptr_q == LAST) begin
            state_d = ST_CLR_ROW;
            ptr_d   = CLR_START;
          end else begin
            state_d = ST_COPY_RD;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine state, pointer, copy data and DONE pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // FILL_CHAR register; read back combinationally through reg_dout.
  always_ff @(posedge clk) begin
    if (reset)                                  fill_char_q <= FILL_CHAR_RST;
    else if (reg_cs && reg_wr && reg_a == REG_FILL) fill_char_q <= reg_din;
  end

endmodule

// File: tb/tb_vram_blit_controller.sv
// Self-checking bench for vram_blit_controller with a behavioural VRAM model.
module tb_vram_blit_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reg_cs = 1'b0, reg_wr = 1'b0, reg_a = 1'b0;
  logic [7:0] reg_din = '0, reg_dout;
  logic       cpu_cs = 1'b0, cpu_wr = 1'b0;
  logic [10:0] cpu_a = '0;
  logic [7:0] cpu_din = '0, cpu_dout;
  logic       cpu_wait;
  logic       vram_cs, vram_wr;
  logic [10:0] vram_a;
  logic [7:0] vram_din, vram_dout;
  logic       vram_wait = 1'b0;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // VRAM model: zero-latency read, write on completing cycle, bulk preload.
  logic [7:0] mem [0:2047];
  logic       preload_req = 1'b0;
  int         preload_mode = 0;

  assign vram_dout = mem[vram_a];

  always @(posedge clk) begin
    if (preload_req) begin
      for (int a = 0; a < 2048; a++)
        mem[a] <= (preload_mode == 0) ? 8'(a) : (8'(a) ^ 8'h5A);
    end else if (vram_cs && !vram_wait && vram_wr) begin
      mem[vram_a] <= vram_din;
    end
  end

  always #5 clk = ~clk;

  vram_blit_controller dut (
    .clk(clk), .reset(reset),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_a(reg_a), .reg_din(reg_din), .reg_dout(reg_dout),
    .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_wait(cpu_wait),
    .vram_cs(vram_cs), .vram_wr(vram_wr), .vram_a(vram_a), .vram_din(vram_din),
    .vram_dout(vram_dout), .vram_wait(vram_wait),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic       a;
    logic       wr;
    logic [7:0] din;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int mode);
    preload_mode = mode;
    preload_req  = 1'b1;
    tick();
    preload_req  = 1'b0;
  endtask

  task automatic reg_write(input logic a, input logic [7:0] d);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_a = a; reg_din = d;
    tick();
    reg_cs = 1'b0; reg_wr = 1'b0;
  endtask

  // Returns in cycle 1 after the command edge.
  task automatic start_cmd(input logic [7:0] cmd);
    reg_write(1'b0, cmd);
  endtask

  // Advance until DONE is seen; cyc is the cycle number after the command.
  task automatic wait_done(input int start, input int budget, output int cyc, output int busy_n);
    cyc = start;
    busy_n = 0;
    while (!done && cyc <= budget) begin
      if (busy) busy_n++;
      tick();
      cyc++;
    end
  endtask

  // mode 0: constant c, 1: (a+64)[7:0], 2: a[7:0]^5A
  task automatic check_mem(input string name, input int lo, input int hi,
                           input int mode, input logic [7:0] c);
    int bad = 0;
    logic [7:0] e;
    for (int a = lo; a <= hi; a++) begin
      e = (mode == 0) ? c : (mode == 1) ? 8'(a + 64) : (8'(a) ^ 8'h5A);
      if (mem[a] !== e) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int cyc, busy_n, reads, rd_bad, dn;
    logic [7:0] e;

    vecs[0] = '{a: 1'b1, wr: 1'b0, din: 8'h00, exp: 8'h20};
    vecs[1] = '{a: 1'b0, wr: 1'b0, din: 8'h00, exp: 8'h00};
    vecs[2] = '{a: 1'b1, wr: 1'b1, din: 8'hA5, exp: 8'h00};
    vecs[3] = '{a: 1'b1, wr: 1'b0, din: 8'h00, exp: 8'hA5};
    vecs[4] = '{a: 1'b0, wr: 1'b1, din: 8'h00, exp: 8'h00};
    vecs[5] = '{a: 1'b0, wr: 1'b0, din: 8'h00, exp: 8'h00};
    vecs[6] = '{a: 1'b1, wr: 1'b1, din: 8'h41, exp: 8'h00};
    vecs[7] = '{a: 1'b1, wr: 1'b0, din: 8'h00, exp: 8'h41};

    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vram_cs", vram_cs, 0);

    // Register table
    for (int i = 0; i < 8; i++) begin
      reg_cs = 1'b1; reg_wr = vecs[i].wr; reg_a = vecs[i].a; reg_din = vecs[i].din;
      #1;
      if (!vecs[i].wr) check($sformatf("reg_vec%0d", i), reg_dout, vecs[i].exp);
      tick();
      reg_cs = 1'b0; reg_wr = 1'b0;
    end
    check("cmd0_no_start", busy, 0);

    // Idle CPU pass-through
    cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_a = 11'd123;
    #1;
    check("idle_vram_cs", vram_cs, 1);
    check("idle_cpu_wait", cpu_wait, 0);
    check("idle_vram_a", vram_a, 123);
    tick();
    cpu_cs = 1'b0;

    // FILL with 8'h41
    start_cmd(8'h01);
    check("fill_busy_c1", busy, 1);
    wait_done(1, 5000, cyc, busy_n);
    check("fill_done_cycle", cyc, 1921);
    check("fill_busy_cycles", busy_n, 1920);
    check("fill_busy_at_done", busy, 0);
    tick();
    check("fill_done_pulse", done, 0);
    check_mem("fill_mem", 0, 1919, 0, 8'h41);

    // SCROLL with ignored CMD write while busy
    preload(0);
    start_cmd(8'h02);
    reg_cs = 1'b1; reg_wr = 1'b0; reg_a = 1'b0;
    #1;
    check("scroll_status", reg_dout, 8'h01);
    tick();
    reg_wr = 1'b1; reg_din = 8'h01;
    tick();
    reg_cs = 1'b0; reg_wr = 1'b0;
    wait_done(3, 8000, cyc, busy_n);
    check("scroll_done_cycle", cyc, 3777);
    tick();
    check("scroll_done_pulse", done, 0);
    check_mem("scroll_copy_mem", 0, 1855, 1, 8'h00);
    check_mem("scroll_clr_mem", 1856, 1919, 0, 8'h41);

    // FILL with CPU reads every 3rd cycle
    preload(2);
    reg_write(1'b1, 8'h2E);
    start_cmd(8'h01);
    cyc = 1; reads = 0; busy_n = 0; rd_bad = 0;
    while (!done && cyc <= 8000) begin
      if (busy) busy_n++;
      if (busy && cyc % 3 == 0) begin
        cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_a = 11'(2000 + reads % 48);
        #1;
        e = 8'(2000 + reads % 48) ^ 8'h5A;
        if (cpu_wait !== 1'b0 || cpu_dout !== e) rd_bad++;
        reads++;
      end
      tick();
      cpu_cs = 1'b0;
      cyc++;
    end
    check("cpurd_bad_reads", rd_bad, 0);
    check("cpurd_done_cycle", cyc, 1921 + reads);
    check("cpurd_busy_cycles", busy_n, 1920 + reads);
    check_mem("cpurd_fill_mem", 0, 1919, 0, 8'h2E);
    check_mem("cpurd_untouched", 2000, 2047, 2, 8'h00);

    // Stalled engine write vs. rising CPU_CS; CMD=3 must select FILL
    reg_write(1'b1, 8'h33);
    start_cmd(8'h03);
    for (int c = 1; c < 10; c++) tick();
    vram_wait = 1'b1;
    #1;
    check("stall_eng_addr", vram_a, 9);
    check("stall_eng_wr", vram_wr, 1);
    for (int c = 11; c <= 14; c++) begin
      tick();
      if (c == 14) vram_wait = 1'b0;
      cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_a = 11'd2047;
      #1;
      check($sformatf("stall_cpu_wait_c%0d", c), cpu_wait, 1);
      check($sformatf("stall_vram_a_c%0d", c), vram_a, 9);
    end
    tick();
    #1;
    check("stall_cpu_served", cpu_wait, 0);
    check("stall_cpu_dout", cpu_dout, 8'hA5);
    check("stall_cpu_addr", vram_a, 2047);
    tick();
    cpu_cs = 1'b0;
    #1;
    check("stall_eng_resume", vram_a, 10);
    wait_done(16, 5000, cyc, busy_n);
    check("stall_done_cycle", cyc, 1926);
    check_mem("stall_fill_mem", 0, 1919, 0, 8'h33);

    // RESET at cycle 500 of a SCROLL
    preload(0);
    start_cmd(8'h02);
    for (int c = 1; c < 500; c++) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done || busy) dn++;
    end
    check("abort_quiet", dn, 0);
    reg_cs = 1'b1; reg_wr = 1'b0; reg_a = 1'b1;
    #1;
    check("abort_fill_char", reg_dout, 8'h20);
    tick();
    reg_cs = 1'b0;
    start_cmd(8'h01);
    wait_done(1, 5000, cyc, busy_n);
    check("refill_done_cycle", cyc, 1921);
    check_mem("refill_mem", 0, 1919, 0, 8'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
